sqrt_fault_monitor: RTL and testbench



---
 rtl/sqrt_fault_pkg.sv | 19 +
 rtl/sqrt_golden_iter.sv | 90 +++++++++
 rtl/sqrt_fault_monitor.sv | 144 ++++++++++++++
 tb/tb_sqrt_fault_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_fault_pkg.sv
// Shared types and sizing for the faulted-sqrt checking stage.
package sqrt_fault_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CMP  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNTW  = 16;
  localparam int DEFAULT_ITERS = DEFAULT_WIDTH / 2;

  // One restoring iteration consumes two radicand bits.
  function automatic int iter_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_golden_iter.sv
// Iterative restoring integer square root, one bit pair per cycle.
module sqrt_golden_iter
  import sqrt_fault_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH/2-1:0] root,
  output logic               done,
  output logic               last
);

  localparam int HALF  = WIDTH / 2;
  localparam int ITERS = iter_count(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);

  logic [WIDTH-1:0] op_q, op_d;
  logic [HALF+1:0]  rem_q, rem_d;
  logic [HALF-1:0]  root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic [HALF+3:0]  rem_sh;
  logic [HALF+1:0]  trial;
  logic             last_iter;

  always_comb begin
    // The upper remainder bits are zero by construction but kept in the compare.
    rem_sh    = {rem_q, op_q[WIDTH-1 -: 2]};
    trial     = {root_q, 2'b01};
    last_iter = active_q && (cnt_q == CW'(ITERS - 1));

    op_d     = op_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = done_q;

    if (start) begin
      op_d     = operand;
      rem_d    = '0;
      root_d   = '0;
      cnt_d    = '0;
      active_d = 1'b1;
      done_d   = 1'b0;
    end else if (active_q) begin
      op_d  = op_q << 2;
      cnt_d = cnt_q + 1'b1;
      if (rem_sh >= {2'b00, trial}) begin
        rem_d  = rem_sh[HALF+1:0] - trial;
        root_d = {root_q[HALF-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[HALF+1:0];
        root_d = {root_q[HALF-2:0], 1'b0};
      end
      if (last_iter) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign root = root_q;
  assign done = done_q;
  assign last = last_iter;

endmodule

// File: rtl/sqrt_fault_monitor.sv
// Checks faulted-sqrt results against a golden engine; counts and captures failures.
module sqrt_fault_monitor
  import sqrt_fault_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNTW  = DEFAULT_CNTW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_operand,
  input  logic [WIDTH/2-1:0] in_result,
  input  logic               clear,
  output logic               busy,
  output logic               mismatch,
  output logic [CNTW-1:0]    checked_count,
  output logic [CNTW-1:0]    error_count,
  output logic               first_valid,
  output logic [WIDTH-1:0]   first_operand,
  output logic [WIDTH/2-1:0] first_expected,
  output logic [WIDTH/2-1:0] first_got
);

  localparam int HALF = WIDTH / 2;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [HALF-1:0]  res_q, res_d;
  logic [CNTW-1:0]  checked_q, checked_d;
  logic [CNTW-1:0]  error_q, error_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fop_q, fop_d;
  logic [HALF-1:0]  fexp_q, fexp_d;
  logic [HALF-1:0]  fgot_q, fgot_d;
  logic             mm_q, mm_d;

  logic             eng_start;
  logic [HALF-1:0]  eng_root;
  logic             eng_done;
  logic             eng_last;

  sqrt_golden_iter #(
    .WIDTH(WIDTH)
  ) u_golden (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .operand (in_operand),
    .root    (eng_root),
    .done    (eng_done),
    .last    (eng_last)
  );

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    checked_d = checked_q;
    error_d   = error_q;
    fv_d      = fv_q;
    fop_d     = fop_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    mm_d      = 1'b0;
    eng_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d    = in_operand;
          res_d     = in_result;
          eng_start = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (eng_last) state_d = CMP;
      end
      CMP: begin
        if (eng_done) begin
          checked_d = (checked_q == CNT_MAX) ? checked_q : checked_q + 1'b1;
          if (eng_root != res_q) begin
            mm_d    = 1'b1;
            error_d = (error_q == CNT_MAX) ? error_q : error_q + 1'b1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fop_d  = opnd_q;
              fexp_d = eng_root;
              fgot_d = res_q;
            end
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides a coincident compare update, but the mismatch pulse survives.
    if (clear) begin
      checked_d = '0;
      error_d   = '0;
      fv_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      res_q     <= '0;
      checked_q <= '0;
      error_q   <= '0;
      fv_q      <= 1'b0;
      fop_q     <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
      mm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      checked_q <= checked_d;
      error_q   <= error_d;
      fv_q      <= fv_d;
      fop_q     <= fop_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
      mm_q      <= mm_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign mismatch       = mm_q;
  assign checked_count  = checked_q;
  assign error_count    = error_q;
  assign first_valid    = fv_q;
  assign first_operand  = fop_q;
  assign first_expected = fexp_q;
  assign first_got      = fgot_q;

endmodule

// File: tb/tb_sqrt_fault_monitor.sv
// Directed bench for sqrt_fault_monitor: main instance plus a 4-bit-counter instance.
module tb_sqrt_fault_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2, clear;
  logic [15:0] in_operand;
  logic [7:0]  in_result;

  logic        in_ready, busy, mismatch, first_valid;
  logic [15:0] checked_count, error_count, first_operand;
  logic [7:0]  first_expected, first_got;

  logic        in_ready2, busy2, mismatch2, first_valid2;
  logic [3:0]  checked_count2, error_count2;
  logic [15:0] first_operand2;
  logic [7:0]  first_expected2, first_got2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sqrt_fault_monitor #(.WIDTH(16), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_operand(in_operand), .in_result(in_result), .clear(clear),
    .busy(busy), .mismatch(mismatch), .checked_count(checked_count),
    .error_count(error_count), .first_valid(first_valid),
    .first_operand(first_operand), .first_expected(first_expected),
    .first_got(first_got)
  );

  sqrt_fault_monitor #(.WIDTH(16), .CNTW(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_operand(in_operand), .in_result(in_result), .clear(clear),
    .busy(busy2), .mismatch(mismatch2), .checked_count(checked_count2),
    .error_count(error_count2), .first_valid(first_valid2),
    .first_operand(first_operand2), .first_expected(first_expected2),
    .first_got(first_got2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Send one pair to the main instance; report the edge (1..9) of the first mismatch, 0 if none.
  task automatic run_vec(input logic [15:0] op, input logic [7:0] res, output int mm_edge);
    mm_edge = 0;
    @(negedge clk);
    in_operand = op; in_result = res; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (mismatch && mm_edge == 0) mm_edge = k;
    end
    $display("[TB] vec op=%04h res=%02h mismatch_edge=%0d checked=%0d errors=%0d",
             op, res, mm_edge, checked_count, error_count);
  endtask

  task automatic run_vec2(input logic [15:0] op, input logic [7:0] res);
    @(negedge clk);
    in_operand = op; in_result = res; in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    $display("[TB] sat vec op=%04h res=%02h checked=%0d errors=%0d",
             op, res, checked_count2, error_count2);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; clear = 1'b0;
    in_operand = '0; in_result = '0;
    #12;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL reset_mismatch: got %0b expected 0", mismatch); end
    tests++; if (checked_count !== 16'd0) begin fails++; $display("FAIL reset_checked: got %0d expected 0", checked_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL reset_errors: got %0d expected 0", error_count); end
    tests++; if (first_valid !== 1'b0) begin fails++; $display("FAIL reset_first_valid: got %0b expected 0", first_valid); end
    tests++; if (in_ready2 !== 1'b1) begin fails++; $display("FAIL reset_in_ready_sat: got %0b expected 1", in_ready2); end
    @(negedge clk); rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_pass();
    int e1, e2;
    run_vec(16'h0000, 8'h00, e1);
    run_vec(16'hFFFF, 8'hFF, e2);
    tests++; if (e1 != 0 || e2 != 0) begin fails++; $display("FAIL pass_no_mismatch: got edges %0d/%0d expected 0/0", e1, e2); end
    tests++; if (checked_count !== 16'd2) begin fails++; $display("FAIL pass_checked: got %0d expected 2", checked_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL pass_errors: got %0d expected 0", error_count); end
    tests++; if (first_valid !== 1'b0) begin fails++; $display("FAIL pass_first_valid: got %0b expected 0", first_valid); end
  endtask

  task automatic test_fail_capture();
    int e1, e2;
    do_clear();
    run_vec(16'h0064, 8'h09, e1);
    tests++; if (e1 != 9) begin fails++; $display("FAIL capture_pulse_edge: got %0d expected 9", e1); end
    tests++; if (error_count !== 16'd1) begin fails++; $display("FAIL capture_errors_1: got %0d expected 1", error_count); end
    run_vec(16'h0051, 8'h00, e2);
    tests++; if (e2 != 9) begin fails++; $display("FAIL capture_pulse_edge2: got %0d expected 9", e2); end
    tests++; if (checked_count !== 16'd2) begin fails++; $display("FAIL capture_checked: got %0d expected 2", checked_count); end
    tests++; if (error_count !== 16'd2) begin fails++; $display("FAIL capture_errors_2: got %0d expected 2", error_count); end
    tests++; if (first_valid !== 1'b1) begin fails++; $display("FAIL capture_first_valid: got %0b expected 1", first_valid); end
    tests++; if (first_operand !== 16'h0064) begin fails++; $display("FAIL capture_operand: got %04h expected 0064", first_operand); end
    tests++; if (first_expected !== 8'h0A) begin fails++; $display("FAIL capture_expected: got %02h expected 0a", first_expected); end
    tests++; if (first_got !== 8'h09) begin fails++; $display("FAIL capture_got: got %02h expected 09", first_got); end
  endtask

  task automatic test_input_ignored();
    do_clear();
    @(negedge clk);
    in_operand = 16'h0090; in_result = 8'h0C; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_operand = 16'hFFFF; in_result = 8'h00;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL calc_in_ready: got %0b expected 0", in_ready); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL calc_busy: got %0b expected 1", busy); end
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] vec op=0090 res=0c with garbage during CALC checked=%0d errors=%0d", checked_count, error_count);
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL ignore_mismatch: got %0b expected 0", mismatch); end
    tests++; if (checked_count !== 16'd1) begin fails++; $display("FAIL ignore_checked: got %0d expected 1", checked_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL ignore_errors: got %0d expected 0", error_count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ignore_ready_back: got %0b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n = 0;
    logic rdy;
    do_clear();
    in_operand = 16'h0090; in_result = 8'h0C; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        if (n < 3) acc[n] = i;
        n++;
        $display("[TB] accept at cycle %0d", i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++; if (n != 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", n); end
    if (n >= 3) begin
      tests++; if (acc[0] != 0 || acc[1] != 10 || acc[2] != 20) begin fails++;
        $display("FAIL b2b_spacing: got %0d/%0d/%0d expected 0/10/20", acc[0], acc[1], acc[2]); end
    end
    tests++; if (checked_count !== 16'd3) begin fails++; $display("FAIL b2b_checked: got %0d expected 3", checked_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL b2b_errors: got %0d expected 0", error_count); end
  endtask

  task automatic test_clear_collision();
    do_clear();
    @(negedge clk);
    in_operand = 16'h0064; in_result = 8'h09; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    $display("[TB] vec op=0064 res=09 with clear on compare edge");
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL collision_mismatch: got %0b expected 1", mismatch); end
    tests++; if (checked_count !== 16'd0) begin fails++; $display("FAIL collision_checked: got %0d expected 0", checked_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL collision_errors: got %0d expected 0", error_count); end
    tests++; if (first_valid !== 1'b0) begin fails++; $display("FAIL collision_first_valid: got %0b expected 0", first_valid); end
  endtask

  task automatic test_reset_mid_calc();
    int e1, e2;
    do_clear();
    @(negedge clk);
    in_operand = 16'h0064; in_result = 8'h0B; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %0b expected 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("[TB] reset during CALC, discarded vector op=0064 res=0b");
    tests++; if (checked_count !== 16'd0) begin fails++; $display("FAIL rst_mid_checked: got %0d expected 0", checked_count); end
    tests++; if (error_count !== 16'd0) begin fails++; $display("FAIL rst_mid_errors: got %0d expected 0", error_count); end
    run_vec(16'h0051, 8'h09, e1);
    tests++; if (e1 != 0 || checked_count !== 16'd1) begin fails++;
      $display("FAIL rst_after_pass: got edge %0d checked %0d expected 0/1", e1, checked_count); end
    run_vec(16'h0051, 8'h08, e2);
    tests++; if (e2 != 9 || error_count !== 16'd1) begin fails++;
      $display("FAIL rst_after_fail: got edge %0d errors %0d expected 9/1", e2, error_count); end
    tests++; if (first_expected !== 8'h09 || first_got !== 8'h08 || first_operand !== 16'h0051) begin fails++;
      $display("FAIL rst_after_capture: got %04h/%02h/%02h expected 0051/09/08", first_operand, first_expected, first_got); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      run_vec2(16'h0004, 8'h00);
      if (i == 14) begin
        tests++; if (checked_count2 !== 4'd15 || error_count2 !== 4'd15) begin fails++;
          $display("FAIL sat_reach: got %0d/%0d expected 15/15", checked_count2, error_count2); end
      end
    end
    tests++; if (checked_count2 !== 4'd15) begin fails++; $display("FAIL sat_checked_held: got %0d expected 15", checked_count2); end
    tests++; if (error_count2 !== 4'd15) begin fails++; $display("FAIL sat_errors_held: got %0d expected 15", error_count2); end
    tests++; if (first_valid2 !== 1'b1 || first_expected2 !== 8'h02 || first_got2 !== 8'h00) begin fails++;
      $display("FAIL sat_capture: got %0b/%02h/%02h expected 1/02/00", first_valid2, first_expected2, first_got2); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_capture();
    test_input_ignored();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid_calc();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
